// File: rtl/rr_mux_arbiter.sv
// rtl/rr_mux_arbiter.sv - two-source round-robin arbiter driving a 2:1 mux into a registered output stage
`timescale 1ns/1ps
module rr_mux_arbiter #(
  parameter int SIZE  = 1,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [SIZE-1:0]  A_DATA,
  input  logic             A_VALID,
  output logic             A_READY,
  input  logic [SIZE-1:0]  B_DATA,
  input  logic             B_VALID,
  output logic             B_READY,
  output logic             SEL,
  output logic [SIZE-1:0]  OUT_DATA,
  output logic             OUT_SRC,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [CNT_W-1:0] CNT_A,
  output logic [CNT_W-1:0] CNT_B
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q;
  logic [SIZE-1:0]  out_data_q;
  logic             out_src_q;
  logic             last_q;
  logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
  logic [CNT_W-1:0] cnt_b_q, cnt_b_d;

  logic             load_ok;
  logic             grant_vld;
  logic             grant_b;
  logic             sel;
  logic [SIZE-1:0]  mux_data;

  // Grant and select: the register may load when empty or draining; held off while in reset
  // so no handshake can complete during reset. On contention the source not granted last wins.
  always_comb begin
    load_ok   = RST_N & ((state_q == ST_EMPTY) | OUT_READY);
    grant_vld = load_ok & (A_VALID | B_VALID);
    grant_b   = B_VALID & (~A_VALID | ~last_q);
    sel       = grant_vld ? grant_b : last_q;
    mux_data  = sel ? B_DATA : A_DATA;
  end

  // Per-source saturating transfer counters: next-state
  always_comb begin
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    if (grant_vld && !grant_b && (cnt_a_q != CNT_MAX)) cnt_a_d = cnt_a_q + CNT_ONE;
    if (grant_vld &&  grant_b && (cnt_b_q != CNT_MAX)) cnt_b_d = cnt_b_q + CNT_ONE;
  end

  // Output stage FSM: EMPTY/FULL with data, source tag and last-grant history registered
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_EMPTY;
      out_data_q <= '0;
      out_src_q  <= 1'b0;
      last_q     <= 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (grant_vld) begin
            out_data_q <= mux_data;
            out_src_q  <= sel;
            last_q     <= sel;
            state_q    <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (grant_vld) begin
            out_data_q <= mux_data;
            out_src_q  <= sel;
            last_q     <= sel;
          end else if (OUT_READY) begin
            state_q    <= ST_EMPTY;
          end
        end
        default: state_q <= ST_EMPTY;
      endcase
    end
  end

  // Counter registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
    end
  end

  assign A_READY   = grant_vld & ~grant_b;
  assign B_READY   = grant_vld &  grant_b;
  assign SEL       = sel;
  assign OUT_DATA  = out_data_q;
  assign OUT_SRC   = out_src_q;
  assign OUT_VALID = (state_q == ST_FULL);
  assign CNT_A     = cnt_a_q;
  assign CNT_B     = cnt_b_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb/tb_rr_mux_arbiter.sv - self-checking bench for rr_mux_arbiter
`timescale 1ns/1ps
module tb_rr_mux_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] a_data, b_data, out_data;
  logic       a_valid, a_ready, b_valid, b_ready, sel, out_src, out_valid, out_ready;
  logic [7:0] cnt_a, cnt_b;

  logic       s_ad, s_bd, s_od;
  logic       s_av, s_ar, s_bv, s_br, s_sel, s_os, s_ov, s_ordy;
  logic [1:0] s_cnt_a, s_cnt_b;

  int n_chk = 0;
  int n_err = 0;

  rr_mux_arbiter #(.SIZE(8), .CNT_W(8)) dut (
    .CLK(clk), .RST_N(rst_n),
    .A_DATA(a_data), .A_VALID(a_valid), .A_READY(a_ready),
    .B_DATA(b_data), .B_VALID(b_valid), .B_READY(b_ready),
    .SEL(sel), .OUT_DATA(out_data), .OUT_SRC(out_src),
    .OUT_VALID(out_valid), .OUT_READY(out_ready),
    .CNT_A(cnt_a), .CNT_B(cnt_b)
  );

  rr_mux_arbiter #(.SIZE(1), .CNT_W(2)) dut_s (
    .CLK(clk), .RST_N(rst_n),
    .A_DATA(s_ad), .A_VALID(s_av), .A_READY(s_ar),
    .B_DATA(s_bd), .B_VALID(s_bv), .B_READY(s_br),
    .SEL(s_sel), .OUT_DATA(s_od), .OUT_SRC(s_os),
    .OUT_VALID(s_ov), .OUT_READY(s_ordy),
    .CNT_A(s_cnt_a), .CNT_B(s_cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Scoreboard: accepted words pushed, delivered words popped and compared
  logic [8:0] sb[$];
  logic [7:0] ea, eb;

  always begin
    @(negedge clk);
    #2;
    if (!rst_n) begin
      sb.delete();
      ea = 8'd0;
      eb = 8'd0;
    end else begin
      chk("cnt_a_model", {24'd0, cnt_a}, {24'd0, ea});
      chk("cnt_b_model", {24'd0, cnt_b}, {24'd0, eb});
      chk("ready_excl", {31'd0, a_ready & b_ready}, 32'd0);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          logic [8:0] e;
          e = sb.pop_front();
          chk("sb_word", {23'd0, out_src, out_data}, {23'd0, e});
        end
      end
      if (a_valid && a_ready) begin
        sb.push_back({1'b0, a_data});
        if (ea != 8'hFF) ea = ea + 8'd1;
      end
      if (b_valid && b_ready) begin
        sb.push_back({1'b1, b_data});
        if (eb != 8'hFF) eb = eb + 8'd1;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic       av;
    logic [7:0] ad;
    logic       bv;
    logic [7:0] bd;
    logic       ordy;
    logic       ear;
    logic       ebr;
    logic       esel;
    logic       eov;
    logic [7:0] eod;
    logic       eos;
  } vec_t;

  vec_t tbl[16];
  int   sat_exp[5];

  initial begin
    tbl[0]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[1]  = '{1'b1, 8'h3C, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0};
    tbl[2]  = '{1'b1, 8'hAA, 1'b1, 8'h55, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h55, 1'b1};
    tbl[3]  = '{1'b1, 8'hAA, 1'b1, 8'h55, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hAA, 1'b0};
    tbl[4]  = '{1'b1, 8'hAA, 1'b1, 8'h55, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h55, 1'b1};
    tbl[5]  = '{1'b1, 8'hAA, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h55, 1'b1};
    tbl[6]  = '{1'b1, 8'hAA, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h55, 1'b1};
    tbl[7]  = '{1'b1, 8'hAA, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h55, 1'b1};
    tbl[8]  = '{1'b1, 8'hAA, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h55, 1'b1};
    tbl[9]  = '{1'b1, 8'hAA, 1'b1, 8'h55, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hAA, 1'b0};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hAA, 1'b0};
    tbl[11] = '{1'b0, 8'h00, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'hC3, 1'b1};
    tbl[12] = '{1'b1, 8'h11, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hC3, 1'b1};
    tbl[13] = '{1'b1, 8'h11, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0};
    tbl[14] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0};
    tbl[15] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11, 1'b0};
    sat_exp = '{1, 2, 3, 3, 3};

    // Reset with random inputs
    rst_n = 1'b0;
    a_valid = 0; b_valid = 0; a_data = 0; b_data = 0; out_ready = 0;
    s_av = 0; s_bv = 0; s_ad = 0; s_bd = 0; s_ordy = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a_valid = 1'($urandom); b_valid = 1'($urandom); out_ready = 1'($urandom);
      a_data = 8'($urandom); b_data = 8'($urandom);
      s_av = 1'($urandom); s_ordy = 1'($urandom);
      #1;
      chk("rst_ov", {31'd0, out_valid}, 32'd0);
      chk("rst_ready", {30'd0, a_ready, b_ready}, 32'd0);
      chk("rst_sel", {31'd0, sel}, 32'd1);
      chk("rst_cnt", {16'd0, cnt_a, cnt_b}, 32'd0);
    end
    @(negedge clk);
    a_valid = 0; b_valid = 0; out_ready = 0; s_av = 0; s_ordy = 0;
    rst_n = 1'b1;
    #1;
    chk("rel_ov", {31'd0, out_valid}, 32'd0);
    chk("rel_ready", {30'd0, a_ready, b_ready}, 32'd0);
    chk("rel_sel", {31'd0, sel}, 32'd1);

    // Table-driven vectors
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      a_valid = tbl[i].av; a_data = tbl[i].ad;
      b_valid = tbl[i].bv; b_data = tbl[i].bd;
      out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("v%0d_ready", i), {30'd0, a_ready, b_ready}, {30'd0, tbl[i].ear, tbl[i].ebr});
      chk($sformatf("v%0d_sel", i), {31'd0, sel}, {31'd0, tbl[i].esel});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_out", i), {22'd0, out_valid, out_src, out_data},
          {22'd0, tbl[i].eov, tbl[i].eos, tbl[i].eod});
    end

    // Asynchronous reset while the output register is full
    @(negedge clk);
    a_valid = 1; a_data = 8'h77; b_valid = 0; out_ready = 0;
    @(posedge clk);
    #1;
    chk("pre_rst_ov", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h77});
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_ov", {23'd0, out_valid, out_data}, 32'd0);
    chk("async_ready", {30'd0, a_ready, b_ready}, 32'd0);
    chk("async_sel", {31'd0, sel}, 32'd1);
    chk("async_cnt", {16'd0, cnt_a, cnt_b}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Contention after reset: A first, then strict alternation
    a_valid = 1; a_data = 8'hAA; b_valid = 1; b_data = 8'h55; out_ready = 1;
    #1;
    chk("first_grant", {29'd0, a_ready, b_ready, sel}, {29'd0, 3'b100});
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("alt%0d", i), {23'd0, out_src, out_data},
          (i % 2 == 0) ? {23'd0, 1'b0, 8'hAA} : {23'd0, 1'b1, 8'h55});
      @(negedge clk);
    end
    a_valid = 0; b_valid = 0;
    #1;
    chk("alt_cnt", {16'd0, cnt_a, cnt_b}, {16'd0, 8'd3, 8'd3});
    @(posedge clk);
    #1;
    chk("alt_drain", {31'd0, out_valid}, 32'd0);

    // Saturating counter on the SIZE=1, CNT_W=2 instance
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      s_av = 1'b1; s_ad = 1'(i % 2); s_ordy = 1'b1;
      @(posedge clk);
      #1;
      chk($sformatf("sat%0d_cnt", i), {30'd0, s_cnt_a}, sat_exp[i]);
      chk($sformatf("sat%0d_out", i), {29'd0, s_ov, s_os, s_od}, {29'd0, 1'b1, 1'b0, 1'(i % 2)});
    end
    @(negedge clk);
    s_av = 1'b0;
    @(posedge clk);
    #1;
    chk("sat_hold", {29'd0, s_ov, s_cnt_a}, {29'd0, 1'b0, 2'd3});

    @(negedge clk);
    @(negedge clk);
    #3;
    chk("sb_empty", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
